// File: rtl/rtx_pixel_packer.sv
// Ray-tracer pixel packer: converts pixels to the PIXEL_W format, merges them into
// WORD_W-bit byte-masked memory words and queues finished words in a fall-through FIFO.
module rtx_pixel_packer #(
    parameter int H_RES      = 1280,
    parameter int V_RES      = 720,
    parameter int PIXEL_W    = 16,
    parameter int WORD_W     = 128,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pixel_valid,
    output logic                        pixel_ready,
    input  logic [23:0]                 pixel_color,
    input  logic [10:0]                 pixel_h,
    input  logic [9:0]                  pixel_v,
    input  logic                        flush,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [WORD_W-1:0]           m_data,
    output logic [WORD_W/8-1:0]         m_strb,
    output logic [ADDR_W-1:0]           m_addr,
    output logic                        m_last,
    output logic [15:0]                 drop_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int STRB_W = WORD_W / 8;
    localparam int LANE_B = PIXEL_W / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [31:0]      H_LIM   = H_RES;
    localparam logic [31:0]      V_LIM   = V_RES;
    localparam logic [31:0]      PPW_C   = WORD_W / PIXEL_W;
    localparam logic [31:0]      PW_C    = PIXEL_W;
    localparam logic [31:0]      LB_C    = LANE_B;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {EMPTY, PARTIAL} acc_state_t;

    acc_state_t          state;
    logic                acc_pend;
    logic [ADDR_W-1:0]   acc_addr;
    logic [WORD_W-1:0]   acc_data;
    logic [STRB_W-1:0]   acc_strb;
    logic                acc_last;

    logic [PIXEL_W-1:0]  px;
    logic [31:0]         lin;
    logic [31:0]         lane;
    logic [ADDR_W-1:0]   word_addr;
    logic [WORD_W-1:0]   lane_data;
    logic [WORD_W-1:0]   lane_mask;
    logic [STRB_W-1:0]   lane_strb;
    logic                in_range;
    logic                is_last;
    logic                accept;
    logic                take;
    logic                same;
    logic [WORD_W-1:0]   cand_data;
    logic [STRB_W-1:0]   cand_strb;
    logic                cand_need;
    logic                old_push;
    logic                push_en;
    logic [WORD_W-1:0]   push_data;
    logic [STRB_W-1:0]   push_strb;
    logic [ADDR_W-1:0]   push_addr;
    logic                push_last;
    logic                pop;
    logic                unused_bits;

    logic [WORD_W-1:0]   mem_data [FIFO_DEPTH];
    logic [STRB_W-1:0]   mem_strb [FIFO_DEPTH];
    logic [ADDR_W-1:0]   mem_addr [FIFO_DEPTH];
    logic                mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    assign unused_bits = ^pixel_color;

    always_comb begin
        px = '0;
        case (PIXEL_W)
            8:       px = PIXEL_W'({pixel_color[23:21], pixel_color[15:13], pixel_color[7:6]});
            32:      px = PIXEL_W'({8'h00, pixel_color});
            default: px = PIXEL_W'({pixel_color[23:19], pixel_color[15:10], pixel_color[7:3]});
        endcase
    end

    assign lin       = 32'(pixel_v) * H_LIM + 32'(pixel_h);
    assign lane      = lin % PPW_C;
    assign word_addr = ADDR_W'(lin / PPW_C);
    assign lane_data = WORD_W'(px) << (lane * PW_C);
    assign lane_mask = WORD_W'({PIXEL_W{1'b1}}) << (lane * PW_C);
    assign lane_strb = STRB_W'({LANE_B{1'b1}}) << (lane * LB_C);
    assign in_range  = (32'(pixel_h) < H_LIM) && (32'(pixel_v) < V_LIM);
    assign is_last   = (32'(pixel_h) == H_LIM - 32'd1) && (32'(pixel_v) == V_LIM - 32'd1);

    assign pixel_ready = fifo_count < DEPTH_C;
    assign accept      = pixel_valid && pixel_ready;
    assign take        = accept && in_range;
    assign pop         = m_valid && m_ready;

    // A word that is complete, frame-final or flushed in the same cycle that the old
    // accumulator must leave is parked (acc_pend) and pushed on the following cycle,
    // keeping the FIFO at one push per clock.
    always_comb begin
        same      = (state == PARTIAL) && !acc_pend && (acc_addr == word_addr);
        cand_data = same ? ((acc_data & ~lane_mask) | lane_data) : lane_data;
        cand_strb = same ? (acc_strb | lane_strb) : lane_strb;
        cand_need = take && ((&cand_strb) || is_last || flush);
        old_push  = (state == PARTIAL) &&
                    (take ? !same : ((acc_pend || flush) && pixel_ready));
        push_en   = old_push || cand_need;
        push_data = old_push ? acc_data : cand_data;
        push_strb = old_push ? acc_strb : cand_strb;
        push_addr = old_push ? acc_addr : word_addr;
        push_last = old_push ? acc_last : is_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            acc_pend <= 1'b0;
            acc_addr <= '0;
            acc_data <= '0;
            acc_strb <= '0;
            acc_last <= 1'b0;
        end else if (old_push && cand_need) begin
            state    <= PARTIAL;
            acc_pend <= 1'b1;
            acc_addr <= word_addr;
            acc_data <= cand_data;
            acc_strb <= cand_strb;
            acc_last <= is_last;
        end else if (cand_need) begin
            state    <= EMPTY;
            acc_pend <= 1'b0;
        end else if (take) begin
            state    <= PARTIAL;
            acc_pend <= 1'b0;
            acc_addr <= word_addr;
            acc_data <= cand_data;
            acc_strb <= cand_strb;
            acc_last <= 1'b0;
        end else if (old_push) begin
            state    <= EMPTY;
            acc_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (accept && !in_range && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_data[wr_ptr] <= push_data;
            mem_strb[wr_ptr] <= push_strb;
            mem_addr[wr_ptr] <= push_addr;
            mem_last[wr_ptr] <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_en, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Stale memory contents are masked so an empty FIFO presents all-zero outputs.
    assign m_valid = fifo_count != '0;
    assign m_data  = m_valid ? mem_data[rd_ptr] : '0;
    assign m_strb  = m_valid ? mem_strb[rd_ptr] : '0;
    assign m_addr  = m_valid ? mem_addr[rd_ptr] : '0;
    assign m_last  = m_valid ? mem_last[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_rtx_pixel_packer.sv
// Scoreboard bench for rtx_pixel_packer (RGB565, 128-bit words, 4-entry FIFO).
module tb_rtx_pixel_packer;

    localparam int FIFO_DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         pixel_valid;
    logic         pixel_ready;
    logic [23:0]  pixel_color;
    logic [10:0]  pixel_h;
    logic [9:0]   pixel_v;
    logic         flush;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic [15:0]  m_strb;
    logic [23:0]  m_addr;
    logic         m_last;
    logic [15:0]  drop_count;
    logic [2:0]   fifo_count;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  strb;
        logic [23:0]  addr;
        logic         last;
    } exp_word_t;

    exp_word_t exp_q[$];
    exp_word_t mon_e;
    int total = 0;
    int bad = 0;

    rtx_pixel_packer #(
        .H_RES(1280), .V_RES(720), .PIXEL_W(16), .WORD_W(128),
        .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(24)
    ) dut (
        .clk(clk), .rst(rst),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .pixel_color(pixel_color), .pixel_h(pixel_h), .pixel_v(pixel_v),
        .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_strb(m_strb),
        .m_addr(m_addr), .m_last(m_last),
        .drop_count(drop_count), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] rgb565(input logic [23:0] c);
        return {c[23:19], c[15:10], c[7:3]};
    endfunction

    function automatic logic [23:0] colorOf(input int p);
        return {8'(p * 37), 8'(p * 11 + 5), 8'(p * 73)};
    endfunction

    function automatic void expectWord(input logic [127:0] data, input logic [15:0] strb,
                                       input logic [23:0] addr, input logic last);
        exp_word_t e;
        e.data = data;
        e.strb = strb;
        e.addr = addr;
        e.last = last;
        exp_q.push_back(e);
    endfunction

    // Drives one pixel from just after a rising edge and returns just after the edge that accepted it.
    task automatic applyStimulus(input int h, input int v, input logic [23:0] color);
        int waited;
        waited = 0;
        pixel_h = 11'(h);
        pixel_v = 10'(v);
        pixel_color = color;
        pixel_valid = 1'b1;
        @(negedge clk);
        while (!pixel_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!pixel_ready) checkOutput("acceptTimeout", 128'(pixel_ready), 128'd1);
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flushPulse();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpectedWord", 128'(m_valid), 128'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("wordData", m_data, mon_e.data);
                checkOutput("wordStrb", 128'(m_strb), 128'(mon_e.strb));
                checkOutput("wordAddr", 128'(m_addr), 128'(mon_e.addr));
                checkOutput("wordLast", 128'(m_last), 128'(mon_e.last));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] d;
        rst = 1'b1;
        pixel_valid = 1'b0;
        pixel_color = '0;
        pixel_h = '0;
        pixel_v = '0;
        flush = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("rstValid", 128'(m_valid), 128'd0);
        checkOutput("rstLast", 128'(m_last), 128'd0);
        checkOutput("rstData", m_data, 128'd0);
        checkOutput("rstStrb", 128'(m_strb), 128'd0);
        checkOutput("rstAddr", 128'(m_addr), 128'd0);
        checkOutput("rstDrop", 128'(drop_count), 128'd0);
        checkOutput("rstCount", 128'(fifo_count), 128'd0);
        checkOutput("rstReady", 128'(pixel_ready), 128'd1);
        @(posedge clk);
        #1;

        // Eight red pixels fill word 0.
        m_ready = 1'b1;
        expectWord({8{16'hF800}}, 16'hFFFF, 24'd0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(i, 0, 24'hFF0000);
        @(negedge clk);
        checkOutput("t1NotEarly", 128'(m_valid), 128'd0);
        @(posedge clk);
        #1;
        applyStimulus(7, 0, 24'hFF0000);
        @(negedge clk);
        checkOutput("t1Latency", 128'(m_valid), 128'd1);
        @(posedge clk);
        #1;
        idleCycles(2);

        // Address change pushes a half word, flush drains the new partial word.
        expectWord({64'h0, {4{16'h07E0}}}, 16'h00FF, 24'd0, 1'b0);
        expectWord(128'h001F, 16'h0003, 24'd2, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(i, 0, 24'h00FF00);
        applyStimulus(16, 0, 24'h0000FF);
        idleCycles(3);
        checkOutput("t2Held", 128'(exp_q.size()), 128'd1);
        flushPulse();
        idleCycles(3);
        checkOutput("t2Drained", 128'(exp_q.size()), 128'd0);

        // Backpressure: four full words fill the FIFO and stall the input.
        m_ready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            d = '0;
            for (int l = 0; l < 8; l++) d[l*16 +: 16] = rgb565(colorOf(w * 8 + l));
            expectWord(d, 16'hFFFF, 24'(160 + w), 1'b0);
        end
        for (int p = 0; p < 32; p++) applyStimulus(p, 1, colorOf(p));
        @(negedge clk);
        checkOutput("t3FifoFull", 128'(fifo_count), 128'd4);
        checkOutput("t3ReadyLow", 128'(pixel_ready), 128'd0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        for (int p = 32; p < 40; p++) applyStimulus(p, 1, colorOf(p));
        idleCycles(8);
        checkOutput("t3Drained", 128'(exp_q.size()), 128'd0);
        checkOutput("t3CountZero", 128'(fifo_count), 128'd0);

        // Final pixel of the frame.
        expectWord({16'h11AA, 112'h0}, 16'hC000, 24'd115199, 1'b1);
        applyStimulus(1279, 719, 24'h123456);
        idleCycles(3);
        checkOutput("t4Drained", 128'(exp_q.size()), 128'd0);

        // Out-of-range pixels are counted and dropped.
        applyStimulus(1280, 5, 24'hABCDEF);
        @(negedge clk);
        checkOutput("t5DropOne", 128'(drop_count), 128'd1);
        checkOutput("t5NoPush", 128'(fifo_count), 128'd0);
        @(posedge clk);
        #1;
        applyStimulus(0, 720, 24'h445566);
        @(negedge clk);
        checkOutput("t5DropTwo", 128'(drop_count), 128'd2);
        @(posedge clk);
        #1;
        pixel_h = 11'd1280;
        pixel_v = 10'd5;
        pixel_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        @(negedge clk);
        checkOutput("t5Saturate", 128'(drop_count), 128'hFFFF);
        checkOutput("t5StillEmpty", 128'(fifo_count), 128'd0);
        @(posedge clk);
        #1;

        // Rewriting the same pixel keeps only the latest colour.
        expectWord(128'h07E0 << 80, 16'h0C00, 24'd320, 1'b0);
        applyStimulus(5, 2, 24'h0000FF);
        applyStimulus(5, 2, 24'h00FF00);
        flushPulse();
        idleCycles(3);
        checkOutput("t6Drained", 128'(exp_q.size()), 128'd0);

        // Reset discards queued words and the partial accumulator.
        m_ready = 1'b0;
        for (int p = 0; p < 27; p++) applyStimulus(p, 3, colorOf(p));
        @(negedge clk);
        checkOutput("t7Queued", 128'(fifo_count), 128'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t7ValidLow", 128'(m_valid), 128'd0);
        checkOutput("t7CountZero", 128'(fifo_count), 128'd0);
        checkOutput("t7DropZero", 128'(drop_count), 128'd0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        flushPulse();
        idleCycles(4);
        checkOutput("t7NoResidue", 128'(fifo_count), 128'd0);

        checkOutput("finalQueue", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
